// File: rtl/vhm_exec_ctrl.sv
// Multi-cycle execution controller for an RV64IM core: sequences decode, execute,
// memory, mul/div and writeback phases, and reports retire count and halt status.
module vhm_exec_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inst_valid,
  input  logic [31:0]      inst,
  output logic             inst_ready,
  input  logic             branch_taken,
  output logic             mem_req,
  output logic             mem_we,
  input  logic             mem_ack,
  output logic             md_start,
  input  logic             md_done,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic             pc_we,
  output logic             pc_sel,
  output logic [2:0]       state,
  output logic             halted,
  output logic [1:0]       err,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam int unsigned TO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_MULDIV = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;

  logic [31:0]      inst_q, inst_nxt;
  logic [TO_W-1:0]  mem_cnt, mem_cnt_nxt;
  logic [2:0]       state_nxt;
  logic [1:0]       err_nxt;
  logic [CNT_W-1:0] retire_nxt;
  logic [4:0]       waddr_nxt;
  logic             inst_ready_nxt, mem_req_nxt, mem_we_nxt, md_start_nxt;
  logic             rf_we_nxt, pc_we_nxt, pc_sel_nxt, halted_nxt;

  logic [2:0] dec_next;
  logic [1:0] dec_err;
  logic       is_branch, is_jump, is_store;

  // Classify the latched instruction; held stable from DECODE through WB.
  always_comb begin
    dec_next  = S_HALT;
    dec_err   = ERR_NONE;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    is_store  = 1'b0;
    if (inst_q != EBREAK) begin
      case (inst_q[6:0])
        OP_LUI, OP_AUIPC, OP_IMM, OP_IMM32: dec_next = S_EXEC;
        OP_JAL, OP_JALR: begin
          dec_next = S_EXEC;
          is_jump  = 1'b1;
        end
        OP_BRANCH: begin
          dec_next  = S_EXEC;
          is_branch = 1'b1;
        end
        OP_OP, OP_OP32: dec_next = (inst_q[31:25] == F7_MULDIV) ? S_MULDIV : S_EXEC;
        OP_LOAD: dec_next = S_MEM;
        OP_STORE: begin
          dec_next = S_MEM;
          is_store = 1'b1;
        end
        default: dec_err = ERR_ILLEGAL;
      endcase
    end
  end

  // Next state plus next value of every registered output.
  always_comb begin
    state_nxt   = state;
    inst_nxt    = inst_q;
    waddr_nxt   = rf_waddr;
    mem_cnt_nxt = mem_cnt;
    err_nxt     = err;
    retire_nxt  = retire_cnt;
    case (state)
      S_IDLE: begin
        if (inst_valid) begin
          state_nxt = S_DECODE;
          inst_nxt  = inst;
          waddr_nxt = inst[11:7];
        end
      end
      S_DECODE: begin
        state_nxt = dec_next;
        if (dec_next == S_HALT) err_nxt = dec_err;
        if (dec_next == S_MEM) mem_cnt_nxt = TO_W'(1);
      end
      S_EXEC:   state_nxt = S_WB;
      S_MEM: begin
        // An ack in the final allowed cycle still completes the access.
        if (mem_ack) begin
          state_nxt = S_WB;
        end else if (mem_cnt >= TO_W'(MEM_TIMEOUT)) begin
          state_nxt = S_HALT;
          err_nxt   = ERR_TIMEOUT;
        end else begin
          mem_cnt_nxt = mem_cnt + TO_W'(1);
        end
      end
      S_MULDIV: if (md_done) state_nxt = S_WB;
      S_WB:     state_nxt = S_IDLE;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_IDLE;
    endcase

    if (state_nxt == S_WB) retire_nxt = retire_cnt + CNT_W'(1);

    inst_ready_nxt = (state_nxt == S_IDLE);
    halted_nxt     = (state_nxt == S_HALT);
    mem_req_nxt    = (state_nxt == S_MEM);
    mem_we_nxt     = (state_nxt == S_MEM) && is_store;
    md_start_nxt   = (state == S_DECODE) && (state_nxt == S_MULDIV);
    pc_we_nxt      = (state_nxt == S_WB);
    pc_sel_nxt     = (state_nxt == S_WB) && (is_jump || (is_branch && branch_taken));
    rf_we_nxt      = (state_nxt == S_WB) && !(is_branch || is_store) && (inst_q[11:7] != 5'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      inst_q     <= 32'd0;
      mem_cnt    <= '0;
      err        <= ERR_NONE;
      retire_cnt <= '0;
      rf_waddr   <= 5'd0;
      inst_ready <= 1'b1;
      halted     <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      md_start   <= 1'b0;
      rf_we      <= 1'b0;
      pc_we      <= 1'b0;
      pc_sel     <= 1'b0;
    end else begin
      state      <= state_nxt;
      inst_q     <= inst_nxt;
      mem_cnt    <= mem_cnt_nxt;
      err        <= err_nxt;
      retire_cnt <= retire_nxt;
      rf_waddr   <= waddr_nxt;
      inst_ready <= inst_ready_nxt;
      halted     <= halted_nxt;
      mem_req    <= mem_req_nxt;
      mem_we     <= mem_we_nxt;
      md_start   <= md_start_nxt;
      rf_we      <= rf_we_nxt;
      pc_we      <= pc_we_nxt;
      pc_sel     <= pc_sel_nxt;
    end
  end

endmodule
